// File: rtl/sdr_cmd_controller_if.sv
// Byte-in / tuning-out bundle between uart_rx, the command controller and the NCO/CIC bank.
interface sdr_cmd_controller_if #(
    parameter int PHASE_WIDTH  = 64,
    parameter int NUM_CHANNELS = 2,
    parameter int GAIN_WIDTH   = 8
);
    logic                                 rx_valid;
    logic [7:0]                           rx_byte;
    logic [NUM_CHANNELS*PHASE_WIDTH-1:0]  phase_inc;
    logic [NUM_CHANNELS-1:0]              phase_upd;
    logic [GAIN_WIDTH-1:0]                cic_gain;
    logic [3:0]                           cur_chan;
    logic                                 busy;
    logic                                 cmd_err;

    modport slave (
        input  rx_valid, rx_byte,
        output phase_inc, phase_upd, cic_gain, cur_chan, busy, cmd_err
    );

    modport master (
        output rx_valid, rx_byte,
        input  phase_inc, phase_upd, cic_gain, cur_chan, busy, cmd_err
    );
endinterface

// File: rtl/sdr_cmd_controller.sv
// UART command decoder for the SDR receiver: per-channel NCO phase increments and shared CIC gain.
// Optional inter-character timeout for CHAN/HEX states is enabled with SDR_CMD_TIMEOUT_EN.
module sdr_cmd_controller #(
    parameter int                     PHASE_WIDTH    = 64,
    parameter int                     NUM_CHANNELS   = 2,
    parameter int                     GAIN_WIDTH     = 8,
    parameter int                     GAIN_MAX       = 3,
    parameter logic [PHASE_WIDTH-1:0] STEP_SMALL     = 64'h1436a8cdf6f3,
    parameter logic [PHASE_WIDTH-1:0] STEP_MED       = 64'hca22980ba57e,
    parameter logic [PHASE_WIDTH-1:0] STEP_LARGE     = 64'h71b375868d170,
    parameter logic [PHASE_WIDTH-1:0] PRESET_A       = 64'h4CF41F212D77318,
    parameter logic [PHASE_WIDTH-1:0] PRESET_B       = 64'h1aa60f8b8911654,
    parameter int                     TIMEOUT_CYCLES = 8000000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sdr_cmd_controller_if.slave  bus
);
    localparam int DIGITS = PHASE_WIDTH / 4;
    localparam int CW     = $clog2(DIGITS + 1);
    localparam logic [PHASE_WIDTH-1:0] NYQ = {1'b0, {(PHASE_WIDTH-1){1'b1}}};

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_CHAN = 2'd1, ST_HEX = 2'd2} state_t;

    // Returns {valid, nibble} for an ASCII hex digit in either case.
    function automatic logic [4:0] hex_decode(input logic [7:0] b);
        logic [4:0] r;
        if (b >= 8'h30 && b <= 8'h39) begin
            r = {1'b1, 4'(b - 8'h30)};
        end else if (b >= 8'h61 && b <= 8'h66) begin
            r = {1'b1, 4'(b - 8'h57)};
        end else if (b >= 8'h41 && b <= 8'h46) begin
            r = {1'b1, 4'(b - 8'h37)};
        end else begin
            r = 5'b0_0000;
        end
        return r;
    endfunction

    state_t                   state_q;
    logic [PHASE_WIDTH-1:0]   phase_q [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0]  upd_q;
    logic [GAIN_WIDTH-1:0]    gain_q;
    logic [3:0]               chan_q;
    logic                     err_q;
    logic [PHASE_WIDTH-5:0]   shift_q;   // first DIGITS-1 nibbles; the last one completes the word
    logic [CW-1:0]            cnt_q;
`ifdef SDR_CMD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0]            tmo_q;
`endif

    logic                     is_dig_s;
    logic [3:0]               dig_s;
    logic [4:0]               hex_dec_s;
    logic [PHASE_WIDTH-1:0]   hex_word_s;
    logic [PHASE_WIDTH-1:0]   hex_res_s;
    logic [PHASE_WIDTH-1:0]   cur_phase_s;
    logic [PHASE_WIDTH-1:0]   step_s;
    logic                     sub_s;
    logic                     is_step_s;
    logic [PHASE_WIDTH:0]     wide_s;
    logic [PHASE_WIDTH-1:0]   step_res_s;
    logic                     wr_en_d;
    logic [PHASE_WIDTH-1:0]   wr_val_d;

    // Byte classification, step arithmetic with clamping, and the channel write request.
    always_comb begin
        is_dig_s   = (bus.rx_byte >= 8'h30) && (bus.rx_byte <= 8'h39);
        dig_s      = 4'(bus.rx_byte - 8'h30);
        hex_dec_s  = hex_decode(bus.rx_byte);
        hex_word_s = {shift_q, hex_dec_s[3:0]};
        hex_res_s  = hex_word_s[PHASE_WIDTH-1] ? NYQ : hex_word_s;

        cur_phase_s = phase_q[0];
        for (int k = 1; k < NUM_CHANNELS; k++) begin
            cur_phase_s = (chan_q == 4'(k)) ? phase_q[k] : cur_phase_s;
        end

        step_s    = '0;
        sub_s     = 1'b0;
        is_step_s = 1'b1;
        case (bus.rx_byte)
            8'h6F:   begin step_s = STEP_SMALL; sub_s = 1'b1; end
            8'h70:   step_s = STEP_SMALL;
            8'h71:   begin step_s = STEP_MED;   sub_s = 1'b1; end
            8'h72:   step_s = STEP_MED;
            8'h6E:   begin step_s = STEP_LARGE; sub_s = 1'b1; end
            8'h6D:   step_s = STEP_LARGE;
            default: is_step_s = 1'b0;
        endcase

        // One extra bit holds either the borrow of a subtract or the carry of an add.
        if (sub_s) begin
            wide_s = {1'b0, cur_phase_s} - {1'b0, step_s};
        end else begin
            wide_s = {1'b0, cur_phase_s} + {1'b0, step_s};
        end

        if (sub_s && wide_s[PHASE_WIDTH]) begin
            step_res_s = '0;
        end else if (wide_s > {1'b0, NYQ}) begin
            step_res_s = NYQ;
        end else begin
            step_res_s = wide_s[PHASE_WIDTH-1:0];
        end

        wr_en_d  = 1'b0;
        wr_val_d = step_res_s;
        if (bus.rx_valid && state_q == ST_IDLE) begin
            if (is_step_s) begin
                wr_en_d = 1'b1;
            end else if (bus.rx_byte == 8'h61) begin
                wr_en_d  = 1'b1;
                wr_val_d = PRESET_A;
            end else if (bus.rx_byte == 8'h62) begin
                wr_en_d  = 1'b1;
                wr_val_d = PRESET_B;
            end else begin
                wr_en_d = 1'b0;
            end
        end else if (bus.rx_valid && state_q == ST_HEX && hex_dec_s[4]
                     && cnt_q == CW'(DIGITS - 1)) begin
            wr_en_d  = 1'b1;
            wr_val_d = hex_res_s;
        end else begin
            wr_en_d = 1'b0;
        end
    end

    // Command FSM with registered increments, gain, channel select and pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_CHANNELS; k++) begin
                phase_q[k] <= PRESET_A;
            end
            upd_q   <= '0;
            gain_q  <= '0;
            chan_q  <= 4'd0;
            err_q   <= 1'b0;
            state_q <= ST_IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
`ifdef SDR_CMD_TIMEOUT_EN
            tmo_q   <= '0;
`endif
        end else begin
            for (int k = 0; k < NUM_CHANNELS; k++) begin
                if (wr_en_d && chan_q == 4'(k)) begin
                    phase_q[k] <= wr_val_d;
                    upd_q[k]   <= 1'b1;
                end else begin
                    upd_q[k]   <= 1'b0;
                end
            end
            err_q <= 1'b0;

            if (bus.rx_valid) begin
                case (state_q)
                    ST_IDLE: begin
                        if (is_dig_s && int'(dig_s) <= GAIN_MAX) begin
                            gain_q <= GAIN_WIDTH'(dig_s);
                        end else if (bus.rx_byte == 8'h63) begin
                            state_q <= ST_CHAN;
                        end else if (bus.rx_byte == 8'h78) begin
                            state_q <= ST_HEX;
                            shift_q <= '0;
                            cnt_q   <= '0;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                    ST_CHAN: begin
                        if (is_dig_s && int'(dig_s) < NUM_CHANNELS) begin
                            chan_q <= dig_s;
                        end else begin
                            err_q <= 1'b1;
                        end
                        state_q <= ST_IDLE;
                    end
                    ST_HEX: begin
                        if (!hex_dec_s[4]) begin
                            err_q   <= 1'b1;
                            state_q <= ST_IDLE;
                        end else if (cnt_q == CW'(DIGITS - 1)) begin
                            state_q <= ST_IDLE;
                        end else begin
                            shift_q <= hex_word_s[PHASE_WIDTH-5:0];
                            cnt_q   <= cnt_q + CW'(1);
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end

`ifdef SDR_CMD_TIMEOUT_EN
            if (state_q != ST_IDLE && !bus.rx_valid && tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                err_q   <= 1'b1;
                state_q <= ST_IDLE;
                tmo_q   <= '0;
            end else if (state_q != ST_IDLE && !bus.rx_valid) begin
                tmo_q <= tmo_q + TW'(1);
            end else begin
                tmo_q <= '0;
            end
`endif
        end
    end

    // Flatten the per-channel registers onto the output bus.
    always_comb begin
        bus.phase_inc = '0;
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            bus.phase_inc[k*PHASE_WIDTH +: PHASE_WIDTH] = phase_q[k];
        end
    end

    assign bus.phase_upd = upd_q;
    assign bus.cic_gain  = gain_q;
    assign bus.cur_chan  = chan_q;
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.cmd_err   = err_q;
endmodule
